pe_macc_stream: RTL
===================

# pe_macc_stream

Pipelined, parametrised signed multiply-accumulate processing element with valid/ready handshakes at input and output. Each element is an operand pair (a, b); a run of elements ending with in_last forms one dot product. The PE accumulates the run, optionally seeded by an external partial sum, and emits the full-width result plus a shifted, saturated narrow copy. It sits in the PE array in place of the single-shot MAC, adding run framing, zero-skip, backpressure and output saturation.

## Interface
- DATA_W, 16: operand width, signed two's complement, even, ≥4
- ACC_W, 40: accumulator/psum width; must satisfy ACC_W ≥ 2*DATA_W
- OUT_W, 16: saturated output width, ≤ ACC_W
- SHIFT, 0: arithmetic right shift applied before saturation, 0..ACC_W-OUT_W
- CNT_W, 8: element counter width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  PE accepts the pair this cycle
- a, b  in  DATA_W  signed operands
- in_last  in  1  pair is the last of the current run
- psum_sel  in  1  sampled with the first pair of a run: 1 = seed with psum_in, 0 = seed with 0
- psum_in  in  ACC_W  signed external partial sum
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  ACC_W  full accumulated result
- out_sat  out  OUT_W  saturate(out_acc >>> SHIFT)
- out_ovf  out  1  saturation occurred on out_sat
- out_cnt  out  CNT_W  number of pairs in the run (saturates at all-ones)

## Operation
- Advance enable en = !out_valid | out_ready; in_ready = en. All pipeline stages and the accumulator update only when en = 1; when en = 0 everything holds.
- Accept: in_valid & in_ready. Pair enters stage 1 with tags {valid, last, first, skip, seed}.
- first flag: internal; 1 after reset and after a last pair is accepted; cleared by accepting a non-last pair. Seed = psum_sel ? psum_in : 0, captured only when first = 1.
- Zero-skip: skip = (a == 0) | (b == 0). Stage-1 product registers hold their previous values (no toggling); stage 2 contributes product 0.
- Stage 1: registers four half-width partial products of a*b. Stage 2: registers the 2*DATA_W signed product, sign-extended to ACC_W.
- Accumulate (stage 2 valid, en = 1): acc_next = (first ? seed : acc) + prod, modulo 2^ACC_W (wraps, no flag). Counter: cnt_next = (first ? 1 : cnt+1), saturating.
- If stage 2 also has last: out_acc ← acc_next, out_cnt ← cnt_next, out_sat/out_ovf computed from acc_next, out_valid ← 1. Accumulator state is then dead until the next first pair.
- out_valid clears on out_ready when no new last result loads the same cycle; a new load with out_ready = 1 keeps out_valid = 1 with new data (back-to-back).
- Saturation: s = acc_next >>> SHIFT; if s > 2^(OUT_W-1)-1 → max, out_ovf=1; if s < -2^(OUT_W-1) → min, out_ovf=1; else truncate, out_ovf=0.
- Single-pair run (first and last together) is legal: result = seed + a*b, cnt = 1.

## Timing
- Reset values: in_ready 1, out_valid 0, out_acc 0, out_sat 0, out_ovf 0, out_cnt 0; all stage valids 0, acc 0, first 1.
- Latency: last pair accepted on edge E → out_valid high after edge E+2 (3 edges inclusive).
- Throughput: one pair per cycle while no result is stalled; bubbles (in_valid = 0) are allowed anywhere within a run.
- Stall: out_valid & !out_ready freezes the whole pipe, including in-flight pairs of the next run; no data lost or duplicated.
- out_* stable while out_valid & !out_ready.
- Reset mid-run or mid-stall discards all in-flight pairs and any pending result; next accepted pair starts a new run.

## Test plan
- Run a=1..4, b=2, psum_sel=0, last on 4th, out_ready=1 -> out_acc=20, out_cnt=4, out_valid one cycle, 3 edges after last accept.
- Single pair a=-32768, b=-32768, psum_sel=1, psum_in=-5 -> out_acc=1073741819, out_sat=32767, out_ovf=1.
- Run a={3,0,-7}, b={5,9,2}, seed 100 -> out_acc=101, out_cnt=3; stage-1 product regs unchanged during the zero pair.
- Two back-to-back 2-pair runs, out_ready=0 for 4 cycles after first result -> in_ready=0 during stall, first result held stable, second result correct afterwards.
- SHIFT=8, run result 0x000012345 -> out_sat=0x0123, out_ovf=0; result -40000<<8 -> out_sat=-32768, out_ovf=1.
- Assert rst_n=0 mid-run with a pending stalled result -> all outputs return to reset values immediately; next run 2*3 -> out_acc=6.

Source files
------------

// File: rtl/pe_macc_stream.sv
// pe_macc_stream
// Pipelined signed multiply-accumulate processing element with run framing.
// Operand pairs (a, b) come in over a valid/ready handshake. A run of pairs
// that ends with in_last forms one dot product. The run can be seeded with
// psum_in. Each result leaves over a valid/ready handshake as the full-width
// sum plus a shifted, saturated narrow copy.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake for one operand pair
//   a, b                 signed operands (DATA_W)
//   in_last              pair closes the current run
//   psum_sel, psum_in    seed choice and seed value, sampled with the first pair
//   out_valid / out_ready output handshake
//   out_acc              full accumulated result (ACC_W)
//   out_sat, out_ovf     saturate(out_acc >>> SHIFT) and its overflow flag
//   out_cnt              pair count of the run, saturating at all-ones
module pe_macc_stream #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              in_last,
  input  logic              psum_sel,
  input  logic [ACC_W-1:0]  psum_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [OUT_W-1:0]  out_sat,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_cnt
);

  localparam int H  = DATA_W / 2;
  localparam int PW = 2 * DATA_W;

  // ---------------------------------------------------------------------------
  // Handshake / control
  // ---------------------------------------------------------------------------
  logic en;
  logic accept;
  logic skip;
  logic first;

  // The whole pipe advances only while no result is stuck at the output.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign skip     = (a == '0) || (b == '0);

  // first marks the next accepted pair as the start of a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first <= 1'b1;
    end else if (accept) begin
      first <= in_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand split into signed high halves and unsigned low halves, each
  // extended to the product width so that all partial products share a width.
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] a_lo, a_hi, b_lo, b_hi;

  always_comb begin
    a_lo           = '0;
    b_lo           = '0;
    a_lo[H-1:0]    = a[H-1:0];
    b_lo[H-1:0]    = b[H-1:0];
    a_hi           = PW'($signed(a[DATA_W-1:H]));
    b_hi           = PW'($signed(b[DATA_W-1:H]));
  end

  // ---------------------------------------------------------------------------
  // Stage 1: partial products and run tags
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0]    s1_pp_ll, s1_pp_lh, s1_pp_hl, s1_pp_hh;
  logic                    s1_valid, s1_last, s1_first, s1_skip;
  logic signed [ACC_W-1:0] s1_seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_skip  <= 1'b0;
      s1_seed  <= '0;
      s1_pp_ll <= '0;
      s1_pp_lh <= '0;
      s1_pp_hl <= '0;
      s1_pp_hh <= '0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_last  <= in_last;
        s1_first <= first;
        s1_skip  <= skip;
        s1_seed  <= (first && psum_sel) ? $signed(psum_in) : '0;
        // Zero pairs leave the multiplier registers untouched.
        if (!skip) begin
          s1_pp_ll <= a_lo * b_lo;
          s1_pp_lh <= a_lo * b_hi;
          s1_pp_hl <= a_hi * b_lo;
          s1_pp_hh <= a_hi * b_hi;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: recombined full product, sign-extended to the accumulator width
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0]    prod_c;
  logic signed [ACC_W-1:0] prod_ext;

  always_comb begin
    prod_c   = (s1_pp_hh <<< DATA_W) + ((s1_pp_hl + s1_pp_lh) <<< H) + s1_pp_ll;
    prod_ext = ACC_W'(prod_c);
  end

  logic                    s2_valid, s2_last, s2_first;
  logic signed [ACC_W-1:0] s2_seed;
  logic signed [ACC_W-1:0] s2_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_first <= 1'b0;
      s2_seed  <= '0;
      s2_prod  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_first <= s1_first;
      s2_seed  <= s1_seed;
      // The stage-1 registers hold stale data for a skipped pair.
      s2_prod  <= s1_skip ? '0 : prod_ext;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator, element counter and saturation
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]          cnt_next;
  logic signed [ACC_W-1:0]   acc_sh;
  logic [ACC_W-OUT_W:0]      sh_hi;
  logic                      sat_ovf;
  logic [OUT_W-1:0]          sat_val;

  always_comb begin
    acc_next = (s2_first ? s2_seed : acc) + s2_prod;

    if (s2_first) begin
      cnt_next = CNT_W'(1);
    end else if (&cnt) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end

    // The value fits in OUT_W exactly when every bit from the OUT_W sign
    // position upward matches the sign bit.
    acc_sh  = acc_next >>> SHIFT;
    sh_hi   = acc_sh[ACC_W-1:OUT_W-1];
    sat_ovf = !((&sh_hi) || (~|sh_hi));
    if (!sat_ovf) begin
      sat_val = acc_sh[OUT_W-1:0];
    end else if (acc_sh[ACC_W-1]) begin
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (en && s2_valid) begin
      acc <= acc_next;
      cnt <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_sat   <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else if (en) begin
      if (s2_valid && s2_last) begin
        out_valid <= 1'b1;
        out_acc   <= acc_next;
        out_sat   <= sat_val;
        out_ovf   <= sat_ovf;
        out_cnt   <= cnt_next;
      end else begin
        // en here means the held result was consumed or none was held.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
